pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. It drives the IF/ID and PC write enables, the IF/ID flush and the ID/EX bubble (zeroing the control word fed to ID/EX, EX/MEM and MEM/WB). It detects load-use hazards and owns a multi-cycle MULT/DIV busy FSM so HI/LO consumers wait. It also keeps a saturating stall-cycle counter for debug.

Parameters:
MD_LATENCY, 4, cycles the multiply/divide unit is busy after issue (must be >= 1)
CNT_W, 16, width of stall_count

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_is_muldiv  in  1  ID instruction is MULT/MULTU/DIV/DIVU
id_reads_hilo  in  1  ID instruction is MFHI/MFLO
id_branch_taken  in  1  branch/jump resolved taken in ID
ex_memread  in  1  instruction in EX is a load
ex_dst  in  5  destination register of EX instruction
pc_we  out  1  PC write enable
ifid_we  out  1  IF/ID register write enable
ifid_flush  out  1  clear IF/ID to NOP on next edge
idex_bubble  out  1  load all-zero control word into ID/EX on next edge
md_start  out  1  issue pulse to MULT/DIV unit
md_busy  out  1  FSM in MD_BUSY
md_done  out  1  final busy cycle
stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- States: RUN, MD_BUSY. Down-counter md_cnt, width clog2(MD_LATENCY) (min 1).
- load_use = ex_memread & (ex_dst != 0) & ((id_uses_rs & id_rs == ex_dst) | (id_uses_rt & id_rt == ex_dst)).
- md_hazard = (state == MD_BUSY) & (id_is_muldiv | id_reads_hilo).
- stall = load_use | md_hazard (combinational from current state and inputs).
- Outputs when reset = 0:
  - pc_we = ifid_we = ~stall
  - idex_bubble = stall
  - ifid_flush = id_branch_taken & ~stall. Stall has priority; a branch seen while stalled is re-evaluated the following cycle.
  - md_start = id_is_muldiv & ~stall & (state == RUN)
  - md_busy = (state == MD_BUSY)
  - md_done = md_busy & (md_cnt == 0)
- FSM transitions:
  - RUN -> MD_BUSY when md_start; md_cnt <= MD_LATENCY-1.
  - MD_BUSY: md_cnt decrements each cycle. When md_cnt == 0, go to RUN.
  - Issue at cycle T: md_busy is high for T+1..T+MD_LATENCY, md_done is high at T+MD_LATENCY, and an MFHI waiting in ID is released at T+MD_LATENCY+1.
  - A back-to-back MULT in ID is stalled the same way and issues on release.
- stall_count:
  - Increments by 1 each non-reset cycle with stall = 1.
  - Holds at all-ones; no wrap.
- Register $0 never creates a hazard.
- Reset (synchronous, also mid-operation, e.g. in MD_BUSY):
  - state = RUN, md_cnt = 0, stall_count = 0.
  - While reset = 1, outputs are forced: pc_we = 0, ifid_we = 0, ifid_flush = 1, idex_bubble = 1, md_start = 0, md_busy = 0, md_done = 0.
  - The first cycle after deassertion uses normal combinational outputs.
- Load-use stall lasts exactly one cycle: the bubble removes the load from EX on the next edge.
- Load-use and md_hazard in the same cycle: one stall cycle is counted; the FSM still advances.

Test Plan:
- Reset held 3 cycles, then released with all inputs 0 -> during reset pc_we = 0, ifid_flush = 1, idex_bubble = 1. After release pc_we = 1, ifid_flush = 0, idex_bubble = 0, stall_count = 0.
- ex_memread = 1, ex_dst = 8, id_rs = 8, id_uses_rs = 1 for one cycle, then ex_memread = 0 -> exactly 1 cycle of pc_we = 0 and idex_bubble = 1; stall_count = 1. Repeat with ex_dst = 0 -> no stall.
- MD_LATENCY = 4: id_is_muldiv at T, then id_reads_hilo held -> md_start at T; md_busy T+1..T+4; md_done at T+4; pc_we = 0 T+1..T+4; pc_we = 1 at T+5; stall_count = 4.
- id_branch_taken = 1 with no hazard -> ifid_flush = 1, pc_we = 1. Same together with load-use -> ifid_flush = 0 and stall = 1; next cycle ifid_flush = 1.
- Assert reset at T+2 of a MULT busy period -> md_busy = 0 from the next edge; after release, MFHI in ID is not stalled.
- CNT_W = 4, stall held 20 cycles -> stall_count saturates at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer with load-use detection and MULT/DIV busy FSM
module pipeline_hazard_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_muldiv,
  input  logic             id_reads_hilo,
  input  logic             id_branch_taken,
  input  logic             ex_memread,
  input  logic [4:0]       ex_dst,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             md_start,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_count
);

  localparam int MCW = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
  localparam logic [MCW-1:0] MD_LOAD = MCW'(MD_LATENCY - 1);

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [MCW-1:0]   md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic in_busy;
  logic md_hazard;
  logic stall;
  logic start_int;
  logic cnt_zero;

  always_comb begin
    load_use  = ex_memread && (ex_dst != 5'd0) &&
                ((id_uses_rs && (id_rs == ex_dst)) || (id_uses_rt && (id_rt == ex_dst)));
    in_busy   = (state_q == MD_BUSY);
    md_hazard = in_busy && (id_is_muldiv || id_reads_hilo);
    stall     = load_use || md_hazard;
    start_int = id_is_muldiv && !stall && (state_q == RUN);
    cnt_zero  = (md_cnt_q == '0);
  end

  // Reset forces a bubble/flush so nothing leaks into the pipe while state is being cleared.
  assign pc_we       = reset ? 1'b0 : !stall;
  assign ifid_we     = reset ? 1'b0 : !stall;
  assign ifid_flush  = reset ? 1'b1 : (id_branch_taken && !stall);
  assign idex_bubble = reset ? 1'b1 : stall;
  assign md_start    = reset ? 1'b0 : start_int;
  assign md_busy     = reset ? 1'b0 : in_busy;
  assign md_done     = reset ? 1'b0 : (in_busy && cnt_zero);
  assign stall_count = stall_cnt_q;

  always_comb begin
    state_d     = state_q;
    md_cnt_d    = md_cnt_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      RUN: begin
        if (start_int) begin
          state_d  = MD_BUSY;
          md_cnt_d = MD_LOAD;
        end
      end
      MD_BUSY: begin
        if (cnt_zero) begin
          state_d = RUN;
        end else begin
          md_cnt_d = md_cnt_q - 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
